// File: rtl/l2_line_responder.sv
// L2 line responder: single-outstanding line fill / writeback server with a
// fixed accept-to-response latency and a simple valid-gated backing store.
module l2_line_responder #(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned MEM_LINES = 1024,
  parameter int unsigned TAG_WIDTH = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_op,
  input  logic [31:0]  req_addr,
  input  logic [511:0] req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_op,
  output logic [31:0]  rsp_addr,
  output logic [511:0] rsp_data,
  output logic [31:0]  fill_count,
  output logic [31:0]  wb_count
);

  localparam int unsigned LINE_W = 512;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WORDS  = LINE_W / ADDR_W;
  localparam int unsigned IDX_W  = $clog2(MEM_LINES);
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_lat_cnt;
  logic [CNT_W-1:0]    w_lat_cnt_nxt;
  logic                w_accept;
  logic                w_busy_done;
  logic                w_rsp_hs;

  logic                r_req_ready;
  logic                r_rsp_valid;
  logic                r_rsp_op;
  logic [ADDR_W-1:0]   r_rsp_addr;
  logic [LINE_W-1:0]   r_rsp_data;
  logic [31:0]         r_fill_count;
  logic [31:0]         r_wb_count;
  logic [31:0]         w_fill_count_nxt;
  logic [31:0]         w_wb_count_nxt;

  logic                r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic [IDX_W-1:0]    w_idx;
  logic [LINE_W-1:0]   w_fill_data;

  logic [MEM_LINES-1:0] r_line_valid;
  logic [LINE_W-1:0]    r_mem [MEM_LINES];

  logic                w_unused_ok;

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_op     = r_rsp_op;
  assign rsp_addr   = r_rsp_addr;
  assign rsp_data   = r_rsp_data;
  assign fill_count = r_fill_count;
  assign wb_count   = r_wb_count;

  // Offset bits and the tag width parameter carry no function here.
  assign w_unused_ok = ^{req_addr[5:0], 32'(TAG_WIDTH)};

  // Line index of the captured request; upper address bits alias.
  assign w_idx = r_addr[6 +: IDX_W];

  // Fill data: stored line when valid, else the address pattern per word.
  always_comb begin
    w_fill_data = {WORDS{r_addr}};
    if (r_line_valid[w_idx]) begin
      w_fill_data = r_mem[w_idx];
    end
  end

  // Next-state, latency countdown and handshake decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_lat_cnt_nxt = r_lat_cnt;
    w_accept      = 1'b0;
    w_busy_done   = 1'b0;
    w_rsp_hs      = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid && r_req_ready) begin
          w_accept      = 1'b1;
          w_lat_cnt_nxt = LAT_LOAD;
          w_state_nxt   = BUSY;
        end
      end
      BUSY: begin
        if (r_lat_cnt == '0) begin
          w_busy_done = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready && r_rsp_valid) begin
          w_rsp_hs    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Completion counters, advanced on the response handshake.
  always_comb begin
    w_fill_count_nxt = r_fill_count;
    w_wb_count_nxt   = r_wb_count;
    if (w_rsp_hs && !r_rsp_op) begin
      w_fill_count_nxt = r_fill_count + 32'd1;
    end
    if (w_rsp_hs && r_rsp_op) begin
      w_wb_count_nxt = r_wb_count + 32'd1;
    end
  end

  // State, request capture, response registers and line valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_lat_cnt    <= '0;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_op     <= 1'b0;
      r_rsp_addr   <= '0;
      r_rsp_data   <= '0;
      r_fill_count <= '0;
      r_wb_count   <= '0;
      r_op         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_line_valid <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_lat_cnt    <= w_lat_cnt_nxt;
      r_req_ready  <= (w_state_nxt == IDLE);
      r_rsp_valid  <= (w_state_nxt == RESP);
      r_fill_count <= w_fill_count_nxt;
      r_wb_count   <= w_wb_count_nxt;
      if (w_accept) begin
        r_op    <= req_op;
        r_addr  <= {req_addr[31:6], 6'b0};
        r_wdata <= req_wdata;
      end
      if (w_busy_done) begin
        r_rsp_op   <= r_op;
        r_rsp_addr <= r_addr;
        r_rsp_data <= r_op ? '0 : w_fill_data;
        if (r_op) begin
          r_line_valid[w_idx] <= 1'b1;
        end
      end
    end
  end

  // Backing store write, committed only as the writeback enters RESP.
  always_ff @(posedge clk) begin
    if (!rst && w_busy_done && r_op) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_l2_line_responder.sv
// Self-checking bench for l2_line_responder: directed vector table, reset and
// wrap corner sequences, and randomized traffic against a line-level model.
module tb_l2_line_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_op = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [511:0] req_wdata = '0;
  logic         rsp_ready = 1'b0;
  int           sel = 0;

  logic         d0_req_ready, d0_rsp_valid, d0_rsp_op;
  logic [31:0]  d0_rsp_addr, d0_fill_count, d0_wb_count;
  logic [511:0] d0_rsp_data;
  logic         d1_req_ready, d1_rsp_valid, d1_rsp_op;
  logic [31:0]  d1_rsp_addr, d1_fill_count, d1_wb_count;
  logic [511:0] d1_rsp_data;

  logic         g_req_ready, g_rsp_valid, g_rsp_op;
  logic [31:0]  g_rsp_addr, g_fill_count, g_wb_count;
  logic [511:0] g_rsp_data;

  always #5 clk = ~clk;

  l2_line_responder #(.LATENCY(4), .MEM_LINES(1024), .TAG_WIDTH(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && (sel == 0)), .req_ready(d0_req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(d0_rsp_valid), .rsp_ready(rsp_ready && (sel == 0)),
    .rsp_op(d0_rsp_op), .rsp_addr(d0_rsp_addr), .rsp_data(d0_rsp_data),
    .fill_count(d0_fill_count), .wb_count(d0_wb_count)
  );

  l2_line_responder #(.LATENCY(1), .MEM_LINES(16), .TAG_WIDTH(12)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && (sel == 1)), .req_ready(d1_req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready && (sel == 1)),
    .rsp_op(d1_rsp_op), .rsp_addr(d1_rsp_addr), .rsp_data(d1_rsp_data),
    .fill_count(d1_fill_count), .wb_count(d1_wb_count)
  );

  assign g_req_ready  = (sel == 1) ? d1_req_ready  : d0_req_ready;
  assign g_rsp_valid  = (sel == 1) ? d1_rsp_valid  : d0_rsp_valid;
  assign g_rsp_op     = (sel == 1) ? d1_rsp_op     : d0_rsp_op;
  assign g_rsp_addr   = (sel == 1) ? d1_rsp_addr   : d0_rsp_addr;
  assign g_rsp_data   = (sel == 1) ? d1_rsp_data   : d0_rsp_data;
  assign g_fill_count = (sel == 1) ? d1_fill_count : d0_fill_count;
  assign g_wb_count   = (sel == 1) ? d1_wb_count   : d0_wb_count;

  int nerr = 0;
  int nchk = 0;
  bit [511:0] mdl [int];
  bit [31:0]  e_fill [2];
  bit [31:0]  e_wb [2];

  typedef struct {
    bit         op;
    bit [31:0]  addr;
    bit [7:0]   wbyte;
    int         bp;
    bit [31:0]  exp_addr;
    bit [511:0] exp_data;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int lat_of();
    return (sel == 1) ? 1 : 4;
  endfunction

  function automatic int key_of(input bit [31:0] a);
    int lines;
    lines = (sel == 1) ? 16 : 1024;
    return sel * 4096 + int'((a >> 6) & 32'(lines - 1));
  endfunction

  function automatic bit [511:0] model_fill(input bit [31:0] a);
    bit [31:0] al;
    al = a & 32'hFFFF_FFC0;
    if (mdl.exists(key_of(a))) return mdl[key_of(a)];
    return {16{al}};
  endfunction

  task automatic clr_model();
    mdl.delete();
    for (int i = 0; i < 2; i++) begin
      e_fill[i] = '0;
      e_wb[i]   = '0;
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_rsp_valid"}, 512'(g_rsp_valid), 512'(0));
    chk({tag, "_req_ready"}, 512'(g_req_ready), 512'(1));
    chk({tag, "_fill_count"}, 512'(g_fill_count), 512'(0));
    chk({tag, "_wb_count"}, 512'(g_wb_count), 512'(0));
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    clr_model();
    @(negedge clk);
    chk_idle_reset("reset");
    chk("reset_rsp_op", 512'(g_rsp_op), 512'(0));
    chk("reset_rsp_addr", 512'(g_rsp_addr), 512'(0));
    chk("reset_rsp_data", g_rsp_data, 512'(0));
  endtask

  // Present a request and leave once it has been accepted.
  task automatic issue(input bit op, input bit [31:0] a, input bit [511:0] wd);
    int t;
    t = 0;
    while (!g_req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_wait", 512'(g_req_ready), 512'(1));
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_req_ready", 512'(g_req_ready), 512'(0));
  endtask

  // Wait for the response, checking latency and payload.
  task automatic wait_rsp(input bit op, input bit [31:0] ea, input bit [511:0] ed, input bit noise);
    int lat;
    lat = 0;
    while (!g_rsp_valid && lat < 300) begin
      if (noise) begin
        rsp_ready = 1'($urandom);
        req_valid = 1'($urandom);
        req_op    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = {16{$urandom}};
      end
      @(negedge clk);
      lat++;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("latency", 512'(lat), 512'(lat_of()));
    chk("rsp_op", 512'(g_rsp_op), 512'(op));
    chk("rsp_addr", 512'(g_rsp_addr), 512'(ea));
    chk("rsp_data", g_rsp_data, ed);
  endtask

  // Hold off the response for bp cycles, then complete the handshake.
  task automatic finish_txn(input bit op, input bit [31:0] ea, input bit [511:0] ed,
                            input int bp, input bit extra);
    for (int i = 0; i < bp; i++) begin
      if (extra) begin
        req_valid = 1'b1; req_op = ~op;
        req_addr = 32'hDEAD_0000 + 32'(i * 64); req_wdata = '1;
      end
      @(negedge clk);
      chk("bp_rsp_valid", 512'(g_rsp_valid), 512'(1));
      chk("bp_req_ready", 512'(g_req_ready), 512'(0));
      chk("bp_rsp_op", 512'(g_rsp_op), 512'(op));
      chk("bp_rsp_addr", 512'(g_rsp_addr), 512'(ea));
      chk("bp_rsp_data", g_rsp_data, ed);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    chk("hs_req_ready", 512'(g_req_ready), 512'(0));
    @(negedge clk);
    rsp_ready = 1'b0;
    if (op) e_wb[sel]++; else e_fill[sel]++;
    chk("post_hs_rsp_valid", 512'(g_rsp_valid), 512'(0));
    chk("post_hs_req_ready", 512'(g_req_ready), 512'(1));
    chk("fill_count", 512'(g_fill_count), 512'(e_fill[sel]));
    chk("wb_count", 512'(g_wb_count), 512'(e_wb[sel]));
  endtask

  task automatic txn(input bit op, input bit [31:0] a, input bit [511:0] wd,
                     input bit [31:0] ea, input bit [511:0] ed,
                     input int bp, input bit extra, input bit noise);
    issue(op, a, wd);
    wait_rsp(op, ea, ed, noise);
    if (op) mdl[key_of(a)] = wd;
    finish_txn(op, ea, ed, bp, extra);
  endtask

  task automatic model_txn(input bit op, input bit [31:0] a, input bit [511:0] wd,
                           input int bp, input bit noise);
    bit [511:0] ed;
    ed = op ? 512'(0) : model_fill(a);
    txn(op, a, wd, a & 32'hFFFF_FFC0, ed, bp, 1'b0, noise);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0]  a;
    bit [511:0] wd;

    vt[0] = '{1'b0, 32'h1234_5678, 8'h00, 10, 32'h1234_5640, {16{32'h1234_5640}}};
    vt[1] = '{1'b1, 32'h0000_0080, 8'hA5, 0,  32'h0000_0080, 512'(0)};
    vt[2] = '{1'b0, 32'h0000_00BF, 8'h00, 2,  32'h0000_0080, {64{8'hA5}}};
    vt[3] = '{1'b1, 32'h0001_0000, 8'h3C, 0,  32'h0001_0000, 512'(0)};
    vt[4] = '{1'b0, 32'h0000_0000, 8'h00, 0,  32'h0000_0000, {64{8'h3C}}};
    vt[5] = '{1'b0, 32'h0000_0040, 8'h00, 1,  32'h0000_0040, {16{32'h0000_0040}}};
    vt[6] = '{1'b1, 32'hFFFF_FFC5, 8'h5A, 3,  32'hFFFF_FFC0, 512'(0)};
    vt[7] = '{1'b0, 32'h0000_FFC0, 8'h00, 0,  32'h0000_FFC0, {64{8'h5A}}};

    // Directed vectors on the LATENCY=4 instance.
    sel = 0;
    do_reset(3);
    for (int i = 0; i < 8; i++) begin
      txn(vt[i].op, vt[i].addr, {64{vt[i].wbyte}}, vt[i].exp_addr, vt[i].exp_data,
          vt[i].bp, vt[i].bp > 0, 1'b0);
    end
    chk("table_fill_total", 512'(g_fill_count), 512'(5));
    chk("table_wb_total", 512'(g_wb_count), 512'(3));

    // Reset during BUSY of a writeback aborts it; valid bits are cleared.
    issue(1'b1, 32'h0000_0100, {64{8'h77}});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clr_model();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", 512'(g_rsp_valid), 512'(0));
    end
    chk_idle_reset("mid_busy_rst");
    txn(1'b0, 32'h0000_0100, '0, 32'h0000_0100, {16{32'h0000_0100}}, 0, 1'b0, 1'b0);
    txn(1'b0, 32'h0000_0080, '0, 32'h0000_0080, {16{32'h0000_0080}}, 0, 1'b0, 1'b0);

    // Reset coincident with a response handshake wins.
    issue(1'b0, 32'h0000_0200, '0);
    wait_rsp(1'b0, 32'h0000_0200, {16{32'h0000_0200}}, 1'b0);
    rsp_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; rst = 1'b0;
    clr_model();
    @(negedge clk);
    chk_idle_reset("rst_vs_hs");

    // Reset coincident with a request wins.
    req_valid = 1'b1; req_op = 1'b1; req_addr = 32'h0000_0300; req_wdata = '1; rst = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk_idle_reset("rst_vs_req");
    txn(1'b0, 32'h0000_0300, '0, 32'h0000_0300, {16{32'h0000_0300}}, 0, 1'b0, 1'b0);

    // Randomized traffic on a few lines with aliasing upper bits.
    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      a[15:6] = 10'($urandom_range(0, 7));
      for (int w = 0; w < 16; w++) wd[w*32 +: 32] = $urandom;
      model_txn(1'($urandom), a, wd, $urandom_range(0, 3), 1'b1);
    end

    // LATENCY=1 instance: latency, aliasing and counter wrap.
    sel = 1;
    do_reset(2);
    txn(1'b0, 32'h0000_0A47, '0, 32'h0000_0A40, {16{32'h0000_0A40}}, 0, 1'b0, 1'b0);
    txn(1'b1, 32'h0000_0400, {16{32'hCAFE_F00D}}, 32'h0000_0400, 512'(0), 0, 1'b0, 1'b0);
    txn(1'b0, 32'h0000_0000, '0, 32'h0000_0000, {16{32'hCAFE_F00D}}, 1, 1'b0, 1'b0);
    force dut1.r_fill_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut1.r_fill_count;
    e_fill[1] = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("forced_fill_count", 512'(g_fill_count), 512'(e_fill[1]));
    txn(1'b0, 32'h0000_0040, '0, 32'h0000_0040, {16{32'h0000_0040}}, 0, 1'b0, 1'b0);
    chk("fill_count_wrapped", 512'(g_fill_count), 512'(0));
    for (int n = 0; n < 20; n++) begin
      a = $urandom;
      for (int w = 0; w < 16; w++) wd[w*32 +: 32] = $urandom;
      model_txn(1'($urandom), a, wd, $urandom_range(0, 2), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
